// File: rtl/ex_stage_if.sv
// Interface bundling the ID/EX-side inputs and the EX/MEM-side outputs of the
// execute stage. The upstream pipeline or testbench uses the master modport.
// The execute stage uses the slave modport.
interface ex_stage_if #(
  parameter int WORD_W = 32
);
  // Upstream (ID/EX) side
  logic              valid_i;
  logic [WORD_W-1:0] data1_i;
  logic [WORD_W-1:0] data2_i;
  logic [WORD_W-1:0] data3_i;
  logic              control_i;
  logic [2:0]        op_i;
  logic [WORD_W-1:0] IR_i;
  logic              flush_i;

  // Downstream (EX/MEM) side
  logic              stall_o;
  logic              valid_o;
  logic [WORD_W-1:0] result_o;
  logic [WORD_W-1:0] store_data_o;
  logic              branch_taken_o;
  logic [WORD_W-1:0] branch_target_o;
  logic [WORD_W-1:0] IR_o;

  modport master (
    output valid_i, data1_i, data2_i, data3_i, control_i, op_i, IR_i, flush_i,
    input  stall_o, valid_o, result_o, store_data_o, branch_taken_o,
           branch_target_o, IR_o
  );

  modport slave (
    input  valid_i, data1_i, data2_i, data3_i, control_i, op_i, IR_i, flush_i,
    output stall_o, valid_o, result_o, store_data_o, branch_taken_o,
           branch_target_o, IR_o
  );
endinterface

// File: rtl/ex_stage.sv
// Execute stage.
// ADD, SLL and BGE finish in one cycle. MUL runs on an iterative shift-add
// multiplier that consumes MUL_BITS multiplier bits per cycle, LSB first.
// MUL holds stall_o high for WORD_W/MUL_BITS cycles.
// MUL_BITS must be 1, 2 or 4.
module ex_stage #(
  parameter int WORD_W   = 32,
  parameter int MUL_BITS = 1
) (
  input  logic       clk_i,
  input  logic       rst_i,
  ex_stage_if.slave  bus
);

  localparam int STEPS = WORD_W / MUL_BITS;
  localparam int CNT_W = $clog2(STEPS);
  localparam int SH_W  = $clog2(WORD_W);
  localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(STEPS - 1);

  typedef enum logic [2:0] {
    OP_ADD = 3'b000,
    OP_MUL = 3'b001,
    OP_SLL = 3'b010,
    OP_BGE = 3'b011
  } op_e;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_MUL  = 1'b1
  } state_e;

  state_e r_state;
  state_e w_state_next;

  // Multiplier working registers
  logic [WORD_W-1:0] r_mul_a;      // multiplicand, shifted left each step
  logic [WORD_W-1:0] r_mul_b;      // multiplier, shifted right each step
  logic [WORD_W-1:0] r_acc;
  logic [CNT_W-1:0]  r_count;
  logic [WORD_W-1:0] r_mul_ir;
  logic [WORD_W-1:0] r_mul_data3;

  // Output registers
  logic              r_valid;
  logic [WORD_W-1:0] r_result;
  logic [WORD_W-1:0] r_store_data;
  logic              r_branch_taken;
  logic [WORD_W-1:0] r_branch_target;
  logic [WORD_W-1:0] r_ir;

  logic [WORD_W-1:0] w_op_b;
  logic [WORD_W-1:0] w_alu_result;
  logic              w_ge;
  logic              w_is_mul;
  logic              w_is_bge;
  logic              w_accept;
  logic              w_mul_done;
  logic [WORD_W-1:0] w_partial;
  logic [WORD_W-1:0] w_acc_next;

  assign w_op_b   = bus.control_i ? bus.data2_i : bus.data3_i;
  assign w_ge     = $signed(bus.data1_i) >= $signed(w_op_b);
  assign w_is_mul = (op_e'(bus.op_i) == OP_MUL);
  assign w_is_bge = (op_e'(bus.op_i) == OP_BGE);

  // Single-cycle ALU result; MUL and reserved ops yield 0 here.
  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    w_alu_result = '0;
    case (op_e'(bus.op_i))
      OP_ADD:  w_alu_result = bus.data1_i + w_op_b;
      OP_SLL:  w_alu_result = bus.data1_i << w_op_b[SH_W-1:0];
      default: w_alu_result = '0;
    endcase
  end

  // Partial product of one multiplier step: sum of shifted multiplicands.
  always_comb begin
    w_partial = '0;
    for (int k = 0; k < MUL_BITS; k++) begin
      if (r_mul_b[k]) w_partial = w_partial + (r_mul_a << k);
    end
  end

  assign w_acc_next = r_acc + w_partial;

  // Next-state logic; flush forces IDLE and blocks acceptance.
  always_comb begin
    w_state_next = r_state;
    w_accept     = 1'b0;
    w_mul_done   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (bus.valid_i && !bus.flush_i) begin
          w_accept = 1'b1;
          if (w_is_mul) w_state_next = S_MUL;
        end
      end
      S_MUL: begin
        if (r_count == LAST_STEP) begin
          w_mul_done   = 1'b1;
          w_state_next = S_IDLE;
        end
      end
      default: w_state_next = S_IDLE;
    endcase
    if (bus.flush_i) begin
      w_state_next = S_IDLE;
      w_mul_done   = 1'b0;
    end
  end

  // State register.
  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk_i) begin
    if (rst_i) r_state <= S_IDLE;
    else       r_state <= w_state_next;
  end

  // Datapath and output registers; valid and branch_taken are single-cycle pulses.
  // NOTE: the multiplier working registers are reset too. They are plain flops, not a memory.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_mul_a         <= '0;
      r_mul_b         <= '0;
      r_acc           <= '0;
      r_count         <= '0;
      r_mul_ir        <= '0;
      r_mul_data3     <= '0;
      r_valid         <= 1'b0;
      r_result        <= '0;
      r_store_data    <= '0;
      r_branch_taken  <= 1'b0;
      r_branch_target <= '0;
      r_ir            <= '0;
    end else if (bus.flush_i) begin
      r_valid        <= 1'b0;
      r_branch_taken <= 1'b0;
    end else begin
      r_valid        <= 1'b0;
      r_branch_taken <= 1'b0;
      if (w_accept) begin
        if (w_is_mul) begin
          r_mul_a     <= bus.data1_i;
          r_mul_b     <= w_op_b;
          r_acc       <= '0;
          r_count     <= '0;
          r_mul_ir    <= bus.IR_i;
          r_mul_data3 <= bus.data3_i;
        end else begin
          r_valid        <= 1'b1;
          r_result       <= w_alu_result;
          r_store_data   <= bus.data3_i;
          r_ir           <= bus.IR_i;
          r_branch_taken <= w_is_bge && w_ge;
          if (w_is_bge) r_branch_target <= bus.data3_i;
        end
      end else if (r_state == S_MUL) begin
        r_acc   <= w_acc_next;
        r_mul_a <= r_mul_a << MUL_BITS;
        r_mul_b <= r_mul_b >> MUL_BITS;
        r_count <= r_count + CNT_W'(1);
        if (w_mul_done) begin
          r_valid      <= 1'b1;
          r_result     <= w_acc_next;
          r_store_data <= r_mul_data3;
          r_ir         <= r_mul_ir;
        end
      end
    end
  end

  assign bus.stall_o         = (r_state == S_MUL);
  assign bus.valid_o         = r_valid;
  assign bus.result_o        = r_result;
  assign bus.store_data_o    = r_store_data;
  assign bus.branch_taken_o  = r_branch_taken;
  assign bus.branch_target_o = r_branch_target;
  assign bus.IR_o            = r_ir;

endmodule

// File: tb/tb_ex_stage.sv
// Testbench for ex_stage.
// The stimulus process pushes hand-computed expectations into a queue.
// A negedge monitor pops one entry and compares it whenever valid_o is high.
module tb_ex_stage;

  logic clk;
  logic rst;

  ex_stage_if #(.WORD_W(32)) bus ();

  ex_stage #(.WORD_W(32), .MUL_BITS(1)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [31:0] result;
    logic [31:0] store;
    logic [31:0] target;
    logic [31:0] ir;
    logic        taken;
    logic        is_bge;
  } exp_t;

  exp_t exp_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h, want %h", name, act, req);
    end
  endtask

  task automatic push_exp(input string name, input logic [2:0] op, input logic [31:0] d3,
                          input logic [31:0] ir, input logic [31:0] res, input logic taken);
    exp_t e;
    e.name   = name;
    e.result = res;
    e.store  = d3;
    e.target = d3;
    e.ir     = ir;
    e.taken  = taken;
    e.is_bge = (op == 3'b011);
    exp_q.push_back(e);
  endtask

  task automatic drive(input logic [2:0] op, input logic [31:0] d1, input logic [31:0] d2,
                       input logic [31:0] d3, input logic ctrl, input logic [31:0] ir);
    bus.valid_i   = 1'b1;
    bus.op_i      = op;
    bus.data1_i   = d1;
    bus.data2_i   = d2;
    bus.data3_i   = d3;
    bus.control_i = ctrl;
    bus.IR_i      = ir;
  endtask

  // Push expectation, present the instruction, hold it until the stage accepts it.
  task automatic issue(input string name, input logic [2:0] op, input logic [31:0] d1,
                       input logic [31:0] d2, input logic [31:0] d3, input logic ctrl,
                       input logic [31:0] ir, input logic [31:0] res, input logic taken);
    logic idle;
    int   budget;
    push_exp(name, op, d3, ir, res, taken);
    drive(op, d1, d2, d3, ctrl, ir);
    budget = 0;
    do begin
      idle = !bus.stall_o;
      @(posedge clk);
      #1;
      budget++;
    end while (!idle && budget < 100);
    if (!idle) check({name, "_accept_timeout"}, 32'd0, 32'd1);
    bus.valid_i = 1'b0;
  endtask

  task automatic check_all_zero(input string name);
    check({name, "_valid"},  {31'd0, bus.valid_o},        32'd0);
    check({name, "_stall"},  {31'd0, bus.stall_o},        32'd0);
    check({name, "_taken"},  {31'd0, bus.branch_taken_o}, 32'd0);
    check({name, "_result"}, bus.result_o,                32'd0);
    check({name, "_store"},  bus.store_data_o,            32'd0);
    check({name, "_target"}, bus.branch_target_o,         32'd0);
    check({name, "_ir"},     bus.IR_o,                    32'd0);
  endtask

  // Monitor: every valid_o cycle must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (bus.valid_o === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("unexpected_valid", bus.result_o, 32'hDEAD_BEEF);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check({e.name, "_result"}, bus.result_o, e.result);
        check({e.name, "_store"},  bus.store_data_o, e.store);
        check({e.name, "_ir"},     bus.IR_o, e.ir);
        check({e.name, "_taken"},  {31'd0, bus.branch_taken_o}, {31'd0, e.taken});
        if (e.is_bge) check({e.name, "_target"}, bus.branch_target_o, e.target);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int cnt;
    rst           = 1'b1;
    bus.valid_i   = 1'b0;
    bus.flush_i   = 1'b0;
    bus.op_i      = 3'b000;
    bus.data1_i   = '0;
    bus.data2_i   = '0;
    bus.data3_i   = '0;
    bus.control_i = 1'b0;
    bus.IR_i      = '0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check_all_zero("reset");
    @(posedge clk);
    #1;

    // ADD register form, immediate wrap, SLL
    issue("add_reg",  3'b000, 32'd5, 32'd99, 32'd7, 1'b0, 32'h1111_1111, 32'd12, 1'b0);
    issue("add_wrap", 3'b000, 32'hFFFF_FFFF, 32'd2, 32'h55, 1'b1, 32'h2222_2222, 32'd1, 1'b0);
    issue("sll",      3'b010, 32'd3, 32'h24, 32'h66, 1'b1, 32'h3333_3333, 32'h30, 1'b0);

    // BGE: signed compare against data2
    issue("bge_neg",  3'b011, 32'hFFFF_FFFF, 32'd1, 32'h40, 1'b1, 32'h4444_0001, 32'd0, 1'b0);
    issue("bge_eq",   3'b011, 32'd1, 32'd1, 32'h40, 1'b1, 32'h4444_0002, 32'd0, 1'b1);
    issue("bge_sgn",  3'b011, 32'd1, 32'hFFFF_FFFF, 32'h80, 1'b1, 32'h4444_0003, 32'd0, 1'b1);

    // MUL with a held ADD behind it
    issue("mul", 3'b001, 32'h0001_0001, 32'd0, 32'h0003_0003, 1'b0, 32'h5555_5555,
          32'h0006_0003, 1'b0);
    push_exp("add_held", 3'b000, 32'h23, 32'h6666_6666, 32'h123, 1'b0);
    drive(3'b000, 32'h100, 32'd0, 32'h23, 1'b0, 32'h6666_6666);
    cnt = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (bus.stall_o) cnt++;
      else break;
    end
    check("mul_stall_cycles", cnt, 32);
    check("mul_valid_after_stall", {31'd0, bus.valid_o}, 32'd1);
    @(posedge clk);
    #1;
    bus.valid_i = 1'b0;
    @(negedge clk);
    check("add_held_valid", {31'd0, bus.valid_o}, 32'd1);
    check("add_held_direct", bus.result_o, 32'h123);

    // Further multiplies: zero operand and signed operand
    @(posedge clk);
    #1;
    issue("mul_zero", 3'b001, 32'd0, 32'd0, 32'h1234_5678, 1'b0, 32'h7777_0001, 32'd0, 1'b0);
    issue("mul_sgn",  3'b001, 32'hFFFF_FFFF, 32'd3, 32'h77, 1'b1, 32'h7777_0002,
          32'hFFFF_FFFD, 1'b0);

    // Flush on MUL cycle 10: no product may appear
    issue("add_pre", 3'b000, 32'd8, 32'd0, 32'd9, 1'b0, 32'h8888_0001, 32'd17, 1'b0);
    drive(3'b001, 32'd7, 32'd0, 32'd9, 1'b0, 32'h8888_0002);
    @(posedge clk);
    #1;
    bus.valid_i = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    bus.flush_i = 1'b1;
    @(posedge clk);
    #1;
    bus.flush_i = 1'b0;
    @(negedge clk);
    check("flush_stall", {31'd0, bus.stall_o}, 32'd0);
    check("flush_valid", {31'd0, bus.valid_o}, 32'd0);
    repeat (40) @(negedge clk);
    check("flush_no_restall", {31'd0, bus.stall_o}, 32'd0);
    @(posedge clk);
    #1;
    issue("add_post_flush", 3'b000, 32'd40, 32'd0, 32'd2, 1'b0, 32'h8888_0003, 32'd42, 1'b0);

    // Flush in IDLE blocks an instruction presented in the same cycle
    drive(3'b000, 32'd1, 32'd0, 32'd1, 1'b0, 32'h8888_0004);
    bus.flush_i = 1'b1;
    @(posedge clk);
    #1;
    bus.valid_i = 1'b0;
    bus.flush_i = 1'b0;
    @(negedge clk);
    check("flush_idle_valid", {31'd0, bus.valid_o}, 32'd0);
    @(posedge clk);
    #1;

    // Reset mid-MUL
    drive(3'b001, 32'd5, 32'd0, 32'd6, 1'b0, 32'h9999_0001);
    @(posedge clk);
    #1;
    bus.valid_i = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check_all_zero("rst_mul");
    repeat (40) @(negedge clk);
    @(posedge clk);
    #1;

    // Reset mid-stream, right after a result is presented
    push_exp("add_pre_rst", 3'b000, 32'h2, 32'h9999_0002, 32'h3, 1'b0);
    drive(3'b000, 32'd1, 32'd0, 32'd2, 1'b0, 32'h9999_0002);
    @(posedge clk);
    #1;
    bus.valid_i = 1'b0;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check_all_zero("rst_stream");
    @(posedge clk);
    #1;

    // Reserved op right after a taken branch
    issue("bge_taken2", 3'b011, 32'd9, 32'd2, 32'h100, 1'b1, 32'hAAAA_0001, 32'd0, 1'b1);
    issue("reserved",   3'b101, 32'd5, 32'd6, 32'h99, 1'b1, 32'hAAAA_0002, 32'd0, 1'b0);
    issue("add_last",   3'b000, 32'h7FFF_FFFF, 32'd1, 32'h5, 1'b1, 32'hAAAA_0003,
          32'h8000_0000, 1'b0);

    repeat (5) @(negedge clk);
    check("queue_drained", exp_q.size(), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
